// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: I-cache port, D-cache port and the
// shared backing-memory port.
interface mem_port_arbiter_if #(
    parameter int LINE_BITS = 128
);
    logic                 i_req_valid;
    logic [31:0]          i_req_addr;
    logic                 i_req_ready;
    logic                 i_resp_valid;
    logic [LINE_BITS-1:0] i_resp_data;

    logic                 d_req_valid;
    logic                 d_req_write;
    logic [31:0]          d_req_addr;
    logic [LINE_BITS-1:0] d_req_wdata;
    logic                 d_req_ready;
    logic                 d_resp_valid;
    logic [LINE_BITS-1:0] d_resp_data;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_write;
    logic [31:0]          mem_addr;
    logic [LINE_BITS-1:0] mem_wdata;
    logic                 mem_resp_valid;
    logic [LINE_BITS-1:0] mem_rdata;

    // The arbiter: serves both caches and masters the memory port.
    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_write, mem_addr, mem_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    // The surroundings: both cache controllers plus the memory model.
    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_write, mem_addr, mem_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the I- and D-caches, one line
// transaction outstanding at a time, round-robin on simultaneous requests.
module mem_port_arbiter #(
    parameter int LINE_BITS   = 128,
    parameter int OFFSET_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_next;
    logic                 last_grant_d;
    logic                 grant_d;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [LINE_BITS-1:0] req_wdata;
    logic [LINE_BITS-1:0] i_data;
    logic [LINE_BITS-1:0] d_data;
    logic                 pick_d;
    logic                 accept;
    logic [31:0]          sel_addr;
    logic [31:0]          line_addr;

    // D wins unless I is also asking and D was the side served last.
    assign pick_d    = bus.d_req_valid && !(bus.i_req_valid && last_grant_d);
    assign accept    = (state == IDLE) && (bus.i_req_valid || bus.d_req_valid);
    assign sel_addr  = pick_d ? bus.d_req_addr : bus.i_req_addr;
    assign line_addr = {sel_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // NOTE: sequential state only ever uses non-blocking assignments, so every
    // flop samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: each always_comb output is given a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept)             state_next = ISSUE;
            ISSUE:   if (bus.mem_req_ready)  state_next = WAIT;
            WAIT:    if (bus.mem_resp_valid) state_next = RESP;
            RESP:                            state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.i_req_ready   = 1'b0;
        bus.d_req_ready   = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.i_resp_valid  = 1'b0;
        bus.d_resp_valid  = 1'b0;
        case (state)
            IDLE: begin
                bus.i_req_ready = bus.i_req_valid && !pick_d;
                bus.d_req_ready = pick_d;
            end
            ISSUE: bus.mem_req_valid = 1'b1;
            RESP: begin
                bus.i_resp_valid = !grant_d;
                bus.d_resp_valid = grant_d;
            end
            default: ;
        endcase
    end

    // NOTE: the request and response data registers are reset too, because
    // mem_* and *_resp_data are visible outputs that must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_d <= 1'b0;
            grant_d      <= 1'b0;
            req_write    <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            i_data       <= '0;
            d_data       <= '0;
        end else begin
            if (accept) begin
                grant_d      <= pick_d;
                last_grant_d <= pick_d;
                req_write    <= pick_d && bus.d_req_write;
                req_addr     <= line_addr;
                req_wdata    <= pick_d ? bus.d_req_wdata : '0;
            end
            // Each side keeps its own last line; a write-back acknowledges with zero.
            if (state == WAIT && bus.mem_resp_valid) begin
                if (grant_d) d_data <= req_write ? '0 : bus.mem_rdata;
                else         i_data <= bus.mem_rdata;
            end
        end
    end

    assign bus.mem_req_write = req_write;
    assign bus.mem_addr      = req_addr;
    assign bus.mem_wdata     = req_wdata;
    assign bus.i_resp_data   = i_data;
    assign bus.d_resp_data   = d_data;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then random traffic against a transaction-schedule model.
module tb_mem_port_arbiter;
    localparam int LB = 128;
    localparam logic [LB-1:0] LINE_A  = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    localparam logic [LB-1:0] WDATA_B = 128'h1111_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_2222;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.LINE_BITS(LB)) bus ();
    mem_port_arbiter #(.LINE_BITS(LB), .OFFSET_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Requester intents: a pending request is held stable until accepted.
    logic          i_pend;
    logic [31:0]   i_addr;
    logic          d_pend;
    logic          d_write;
    logic [31:0]   d_addr;
    logic [LB-1:0] d_wdata;

    // Environment knobs for the next accepted transaction and the memory.
    logic          rst_req;
    int            next_s;
    int            next_r;
    logic [LB-1:0] next_rdata;
    int unsigned   spur_pct;
    logic          force_spur;
    logic          rand_ready;

    // Model: one transaction with ready-stall s and extra wait cycles r.
    // Relative to acceptance (rel 0): memory request valid for rel 1..1+s,
    // response arrives at rel 2+s+r, resp pulse at rel 3+s+r.
    typedef struct {
        logic          side_d;
        logic          write;
        logic [31:0]   addr;
        logic [LB-1:0] wdata;
        logic [LB-1:0] rdata;
        int            s;
        int            r;
    } txn_t;

    txn_t          m_txn;
    logic          m_busy;
    int            m_rel;
    logic          m_last_d;
    logic [LB-1:0] m_i_data;
    logic [LB-1:0] m_d_data;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, want %b", name, act, exp);
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic check_line(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [LB-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_rel    = 0;
        m_last_d = 1'b0;
        m_i_data = '0;
        m_d_data = '0;
        m_txn.s  = 0;
        m_txn.r  = 0;
        i_pend   = 1'b0;
        d_pend   = 1'b0;
    endtask

    task automatic issue_i(input logic [31:0] a);
        i_pend = 1'b1;
        i_addr = a;
    endtask

    task automatic issue_d(input logic w, input logic [31:0] a, input logic [LB-1:0] wd);
        d_pend  = 1'b1;
        d_write = w;
        d_addr  = a;
        d_wdata = wd;
    endtask

    task automatic set_mem(input int s, input int r, input logic [LB-1:0] rd);
        next_s     = s;
        next_r     = r;
        next_rdata = rd;
    endtask

    task automatic drive_inputs();
        logic in_issue;
        logic in_wait;
        logic resp_now;
        reset           = rst_req;
        bus.i_req_valid = i_pend && !rst_req;
        bus.i_req_addr  = i_addr;
        bus.d_req_valid = d_pend && !rst_req;
        bus.d_req_write = d_write;
        bus.d_req_addr  = d_addr;
        bus.d_req_wdata = d_wdata;
        in_issue = m_busy && m_rel >= 1 && m_rel <= 1 + m_txn.s;
        in_wait  = m_busy && m_rel >= 2 + m_txn.s && m_rel <= 2 + m_txn.s + m_txn.r;
        resp_now = m_busy && m_rel == 2 + m_txn.s + m_txn.r;
        if (in_issue) bus.mem_req_ready = (m_rel == 1 + m_txn.s);
        else          bus.mem_req_ready = rand_ready && ($urandom_range(0, 1) == 1);
        if (in_wait)  bus.mem_resp_valid = resp_now;
        else          bus.mem_resp_valid = force_spur || ($urandom_range(0, 99) < spur_pct);
        bus.mem_rdata = resp_now ? m_txn.rdata : rand_line();
    endtask

    // Compare every DUT output against the model, then advance the model.
    task automatic compare_and_update();
        logic win_d;
        logic exp_mv;
        logic exp_resp;
        int   resp_rel;
        win_d    = bus.d_req_valid && (!bus.i_req_valid || !m_last_d);
        resp_rel = 3 + m_txn.s + m_txn.r;
        exp_mv   = m_busy && m_rel >= 1 && m_rel <= 1 + m_txn.s;
        exp_resp = m_busy && m_rel == resp_rel;
        check_bit("i_req_ready", bus.i_req_ready, !m_busy && bus.i_req_valid && !win_d);
        check_bit("d_req_ready", bus.d_req_ready, !m_busy && win_d);
        check_bit("mem_req_valid", bus.mem_req_valid, exp_mv);
        if (exp_mv) begin
            check_word("mem_addr", bus.mem_addr, m_txn.addr);
            check_bit("mem_req_write", bus.mem_req_write, m_txn.write);
            if (m_txn.write) check_line("mem_wdata", bus.mem_wdata, m_txn.wdata);
        end
        check_bit("i_resp_valid", bus.i_resp_valid, exp_resp && !m_txn.side_d);
        check_bit("d_resp_valid", bus.d_resp_valid, exp_resp && m_txn.side_d);
        check_line("i_resp_data", bus.i_resp_data, m_i_data);
        check_line("d_resp_data", bus.d_resp_data, m_d_data);

        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (bus.i_req_valid || bus.d_req_valid) begin
                m_busy       = 1'b1;
                m_rel        = 1;
                m_last_d     = win_d;
                m_txn.side_d = win_d;
                m_txn.write  = win_d && d_write;
                m_txn.addr   = (win_d ? d_addr : i_addr) & 32'hFFFF_FFF0;
                m_txn.wdata  = d_wdata;
                m_txn.rdata  = next_rdata;
                m_txn.s      = next_s;
                m_txn.r      = next_r;
                if (win_d) d_pend = 1'b0;
                else       i_pend = 1'b0;
            end
        end else begin
            if (m_rel == 2 + m_txn.s + m_txn.r) begin
                if (m_txn.side_d) m_d_data = m_txn.write ? '0 : m_txn.rdata;
                else              m_i_data = m_txn.rdata;
            end
            if (m_rel == resp_rel) m_busy = 1'b0;
            else                   m_rel++;
        end
    endtask

    // One clock cycle: drive after the rising edge, check at the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        drive_inputs();
        @(negedge clk);
        compare_and_update();
    endtask

    initial begin
        int            grants;
        int            lat;
        logic          seen;
        logic [3:0]    order_exp;

        reset      = 1'b1;
        rst_req    = 1'b1;
        i_pend     = 1'b0;
        d_pend     = 1'b0;
        i_addr     = '0;
        d_addr     = '0;
        d_write    = 1'b0;
        d_wdata    = '0;
        spur_pct   = 0;
        force_spur = 1'b0;
        rand_ready = 1'b0;
        set_mem(0, 0, '0);
        bus.i_req_valid    = 1'b0;
        bus.i_req_addr     = '0;
        bus.d_req_valid    = 1'b0;
        bus.d_req_write    = 1'b0;
        bus.d_req_addr     = '0;
        bus.d_req_wdata    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        m_txn.side_d = 1'b0;
        m_txn.write  = 1'b0;
        m_txn.addr   = '0;
        m_txn.wdata  = '0;
        m_txn.rdata  = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset values.
        @(negedge clk);
        check_bit("rst_i_ready", bus.i_req_ready, 1'b0);
        check_bit("rst_d_ready", bus.d_req_ready, 1'b0);
        check_bit("rst_mem_valid", bus.mem_req_valid, 1'b0);
        check_bit("rst_mem_write", bus.mem_req_write, 1'b0);
        check_word("rst_mem_addr", bus.mem_addr, 32'h0);
        check_line("rst_mem_wdata", bus.mem_wdata, '0);
        check_bit("rst_i_resp_valid", bus.i_resp_valid, 1'b0);
        check_bit("rst_d_resp_valid", bus.d_resp_valid, 1'b0);
        check_line("rst_i_resp_data", bus.i_resp_data, '0);
        check_line("rst_d_resp_data", bus.d_resp_data, '0);
        rst_req = 1'b0;

        // I-only read, zero stalls: response pulses 3 cycles after acceptance.
        set_mem(0, 0, LINE_A);
        issue_i(32'h0000_1234);
        cycle();
        check_bit("A_i_ready", bus.i_req_ready, 1'b1);
        check_bit("A_d_ready", bus.d_req_ready, 1'b0);
        cycle();
        check_bit("A_mem_valid", bus.mem_req_valid, 1'b1);
        check_word("A_mem_addr", bus.mem_addr, 32'h0000_1230);
        check_bit("A_mem_write", bus.mem_req_write, 1'b0);
        cycle();
        check_bit("A_early_resp", bus.i_resp_valid, 1'b0);
        cycle();
        check_bit("A_i_resp_valid", bus.i_resp_valid, 1'b1);
        check_line("A_i_resp_data", bus.i_resp_data, LINE_A);
        check_bit("A_d_resp_valid", bus.d_resp_valid, 1'b0);
        cycle();
        check_bit("A_pulse_end", bus.i_resp_valid, 1'b0);

        // D write-back: aligned address, write flag and data forwarded, zero ack.
        set_mem(0, 0, rand_line());
        issue_d(1'b1, 32'h0000_2008, WDATA_B);
        cycle();
        check_bit("B_d_ready", bus.d_req_ready, 1'b1);
        cycle();
        check_word("B_mem_addr", bus.mem_addr, 32'h0000_2000);
        check_bit("B_mem_write", bus.mem_req_write, 1'b1);
        check_line("B_mem_wdata", bus.mem_wdata, WDATA_B);
        cycle();
        cycle();
        check_bit("B_d_resp_valid", bus.d_resp_valid, 1'b1);
        check_line("B_d_resp_data", bus.d_resp_data, '0);
        check_bit("B_i_resp_valid", bus.i_resp_valid, 1'b0);
        cycle();

        // Both sides requesting continuously from reset: D, I, D, I.
        rst_req = 1'b1;
        cycle();
        rst_req   = 1'b0;
        order_exp = 4'b0101;
        grants    = 0;
        set_mem(0, 0, rand_line());
        issue_i(32'h0000_3000);
        issue_d(1'b0, 32'h0000_4000, '0);
        for (int c = 0; c < 40 && grants < 4; c++) begin
            cycle();
            if (bus.i_req_ready || bus.d_req_ready) begin
                check_bit($sformatf("C_grant%0d_is_d", grants), bus.d_req_ready, order_exp[grants]);
                grants++;
            end
            if (!i_pend) issue_i(i_addr + 32'h40);
            if (!d_pend) issue_d(1'b0, d_addr + 32'h40, '0);
        end
        check_word("C_grant_count", grants, 32'd4);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;

        // Back-pressure 3 cycles, response in the 5th wait cycle: latency 10.
        set_mem(3, 4, rand_line());
        issue_i(32'h0000_5678);
        cycle();
        check_bit("D_accept", bus.i_req_ready, 1'b1);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            cycle();
            if (bus.i_resp_valid) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check_word("D_latency", lat, 32'd10);

        // Reset while waiting, then a spurious memory response in IDLE.
        set_mem(0, 3, rand_line());
        issue_d(1'b0, 32'h0000_6040, '0);
        cycle();
        cycle();
        cycle();
        rst_req = 1'b1;
        cycle();
        rst_req    = 1'b0;
        force_spur = 1'b1;
        cycle();
        check_bit("E_mem_valid", bus.mem_req_valid, 1'b0);
        check_bit("E_mem_write", bus.mem_req_write, 1'b0);
        check_word("E_mem_addr", bus.mem_addr, 32'h0);
        check_line("E_mem_wdata", bus.mem_wdata, '0);
        check_line("E_i_resp_data", bus.i_resp_data, '0);
        check_line("E_d_resp_data", bus.d_resp_data, '0);
        cycle();
        force_spur = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            check_bit("E_no_d_resp", bus.d_resp_valid, 1'b0);
            check_bit("E_no_i_resp", bus.i_resp_valid, 1'b0);
        end

        // A request arriving in RESP waits for the following IDLE cycle.
        set_mem(0, 0, rand_line());
        issue_i(32'h0000_7000);
        cycle();
        cycle();
        cycle();
        issue_d(1'b0, 32'h0000_8000, '0);
        cycle();
        check_bit("F_i_resp_valid", bus.i_resp_valid, 1'b1);
        check_bit("F_d_ready_in_resp", bus.d_req_ready, 1'b0);
        cycle();
        check_bit("F_d_ready_in_idle", bus.d_req_ready, 1'b1);

        // Random traffic, stalls, spurious responses and occasional resets.
        spur_pct   = 20;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            set_mem(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), rand_line());
            if (!i_pend && $urandom_range(0, 2) == 0) issue_i($urandom);
            if (!d_pend && $urandom_range(0, 2) == 0)
                issue_d(1'($urandom_range(0, 1)), $urandom, rand_line());
            rst_req = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
